pixel_readout_capture: RTL and testbench
========================================

Name: pixel_readout_capture

Overview:
Receive-side partner of the sensor sequencer. Watches the convert and read_1..read_4 strobes that the sequencer drives on negedge clk, and samples the shared gray-coded 8-bit pixel bus during each read phase. Converts each sample to binary, tags it with its pixel index, and queues it in a small FIFO with a valid/ready output stream. Flags protocol errors: out-of-order strobes, short strobes and FIFO overflow.

Parameters:
DATA_W, 8, pixel data width (matches the 8-bit gray counter)
SETTLE_CYCLES, 2, posedges the read strobe must be high before sampling, 1..4
FIFO_DEPTH, 4, output FIFO entries, power of 2

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-low reset
convert  input  1  sequencer convert phase strobe
read_1  input  1  read strobe for pixel 0
read_2  input  1  read strobe for pixel 1
read_3  input  1  read strobe for pixel 2
read_4  input  1  read strobe for pixel 3
data_in  input  DATA_W  gray-coded pixel bus, valid while a read strobe is high
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts head
out_pixel  output  DATA_W  binary pixel value at head
out_idx  output  2  pixel index at head, 0..3
frame_done  output  1  one-cycle pulse after the pixel-3 read phase ends
seq_err  output  1  sticky: strobe out of order, or more than one strobe high
short_err  output  1  sticky: strobe dropped before the sample point
overflow  output  1  sticky: push attempted while FIFO full, sample dropped

Behaviour:
- Reset (reset=0, async): FSM to IDLE, exp_idx=0, settle count=0, FIFO flushed. All outputs 0. Reset mid-frame discards everything.
- Edge detect: registered copies of convert and read_k. A rising edge is cur=1 with prev=0. Convert falling edge is cur=0 with prev=1.
- FSM states: IDLE, ARMED, SETTLE, HOLD.
- IDLE -> ARMED on convert falling edge: exp_idx=0; seq_err, short_err and overflow cleared. FIFO contents kept.
- Convert falling edge in any other state: re-arm the same way. An abandoned phase gets no push.
- ARMED, exactly one read_k rising:
  - k-1==exp_idx: go to SETTLE, count=1.
  - otherwise: set seq_err and stay ARMED.
- Two or more strobes high in the same cycle, in any state: set seq_err, go to ARMED; no push.
- SETTLE, active strobe high:
  - count<SETTLE_CYCLES: count++.
  - count==SETTLE_CYCLES: capture that cycle, go to HOLD.
  - SETTLE_CYCLES=1 captures on the rising-edge cycle, going from ARMED straight to HOLD.
- SETTLE, strobe low before capture: set short_err, exp_idx++, no push. Go to ARMED, or to IDLE with a frame_done pulse if exp_idx was 3.
- Capture: push {exp_idx, gray2bin(data_in)}. gray2bin: b[7]=g[7], b[i]=b[i+1]^g[i].
- HOLD, strobe falls: exp_idx++. If exp_idx was 3: frame_done=1 for one cycle, go to IDLE. Else go to ARMED.
- FIFO:
  - Push visible on out_valid the cycle after capture (latency 1).
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push while full with no pop: drop the sample, set overflow.
  - Pointers wrap modulo FIFO_DEPTH; occupancy count is log2(FIFO_DEPTH)+1 bits.
  - out_pixel and out_idx hold the head entry; don't-care when out_valid=0, but driven 0 after reset.
- Strobes outside a frame (IDLE): ignored, no error.

Decomposition:
- Shared package pixel_pkg holds:
  - state enum {IDLE, ARMED, SETTLE, HOLD};
  - gray2bin function, parameterised by DATA_W;
  - PIX_PER_FRAME=4;
  - entry typedef {idx[1:0], pixel[DATA_W-1:0]}.
- One sub-module, pixel_fifo: sync FIFO with push/pop/full/empty and the same async active-low reset.

Test Plan:
- Nominal frame, SETTLE_CYCLES=2, out_ready=1: convert 255 cycles then low; read_1..read_4 each 5 cycles with data_in=0x00, 0x07, 0xAC, 0x80 -> out (idx,pixel) = (0,0), (1,5), (2,200), (3,255); frame_done pulses once, 1 cycle after read_4 falls; no error flags.
- Backpressure: out_ready=0 for the whole frame, FIFO_DEPTH=4 -> 4 entries held, out_valid=1, overflow=0. Repeat with FIFO_DEPTH=2 -> entries idx 0,1 kept, overflow=1 after the third capture.
- Out of order: after arming, read_3 pulses first -> seq_err=1, no push; the following read_1 is still accepted as idx 0.
- Short strobe: read_1 high for 1 cycle with SETTLE_CYCLES=2 -> short_err=1, no push; read_2 accepted as idx 1.
- Full with simultaneous pop: FIFO full, capture in the same cycle as out_ready=1 -> occupancy unchanged, overflow=0, order preserved.
- Reset mid-frame: drive reset low during the read_2 SETTLE phase -> all outputs 0 immediately; after release, strobes are ignored until the next convert falling edge.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel readout capture path: FSM states,
// FIFO entry layout and the gray-to-binary conversion of the pixel bus.
package pixel_pkg;

    localparam int PIX_DATA_W    = 8;
    localparam int PIX_PER_FRAME = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SETTLE,
        HOLD
    } state_t;

    typedef struct packed {
        logic [1:0]            idx;
        logic [PIX_DATA_W-1:0] pixel;
    } entry_t;

    // Each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [PIX_DATA_W-1:0] gray2bin(input logic [PIX_DATA_W-1:0] g);
        logic [PIX_DATA_W-1:0] b;
        b[PIX_DATA_W-1] = g[PIX_DATA_W-1];
        for (int i = PIX_DATA_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO; a push while full is accepted only when a pop
// frees the head slot in the same cycle.
module pixel_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          pop_ok;
    logic          push_ok;

    assign full      = (count_reg == DEPTH_C);
    assign empty     = (count_reg == '0);
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    // Head reads as zero when empty so the outputs are clean after reset.
    assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/pixel_readout_capture.sv
// Receive side of the sensor sequencer: tracks the convert/read strobes,
// samples the gray-coded pixel bus once per read phase and queues the result.
module pixel_readout_capture
    import pixel_pkg::*;
#(
    parameter int DATA_W        = PIX_DATA_W,
    parameter int SETTLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              convert,
    input  logic              read_1,
    input  logic              read_2,
    input  logic              read_3,
    input  logic              read_4,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pixel,
    output logic [1:0]        out_idx,
    output logic              frame_done,
    output logic              seq_err,
    output logic              short_err,
    output logic              overflow
);
    localparam logic [1:0] LAST_IDX = 2'(PIX_PER_FRAME - 1);
    localparam logic [2:0] SETTLE_C = 3'(SETTLE_CYCLES);

    state_t     state_reg, state_next;
    logic [1:0] exp_idx_reg, exp_idx_next;
    logic [2:0] settle_cnt_reg, settle_cnt_next;
    logic       seq_err_reg, seq_err_next;
    logic       short_err_reg, short_err_next;
    logic       overflow_reg, overflow_next;
    logic       frame_done_reg, frame_done_next;
    logic       conv_prev_reg;
    logic [3:0] rd_prev_reg;

    logic [3:0] rd_cur;
    logic [3:0] rd_rise;
    logic [3:0] exp_onehot;
    logic       conv_fall;
    logic       multi_hot;
    logic       active;
    logic       last_pix;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_drop;
    entry_t     push_entry;
    entry_t     head_entry;

    assign rd_cur = {read_4, read_3, read_2, read_1};

    for (genvar gi = 0; gi < PIX_PER_FRAME; gi++) begin : g_edge
        assign rd_rise[gi] = rd_cur[gi] & ~rd_prev_reg[gi];
    end

    assign conv_fall  = ~convert & conv_prev_reg;
    assign multi_hot  = (rd_cur & (rd_cur - 4'd1)) != 4'd0;
    assign exp_onehot = 4'd1 << exp_idx_reg;
    assign active     = rd_cur[exp_idx_reg];
    assign last_pix   = (exp_idx_reg == LAST_IDX);
    assign push_entry = {exp_idx_reg, gray2bin(data_in)};
    assign pop        = out_valid && out_ready;
    assign fifo_drop  = push && fifo_full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            exp_idx_reg    <= '0;
            settle_cnt_reg <= '0;
            seq_err_reg    <= 1'b0;
            short_err_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            conv_prev_reg  <= 1'b0;
            rd_prev_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            exp_idx_reg    <= exp_idx_next;
            settle_cnt_reg <= settle_cnt_next;
            seq_err_reg    <= seq_err_next;
            short_err_reg  <= short_err_next;
            overflow_reg   <= overflow_next;
            frame_done_reg <= frame_done_next;
            conv_prev_reg  <= convert;
            rd_prev_reg    <= rd_cur;
        end
    end

    always_comb begin
        state_next      = state_reg;
        exp_idx_next    = exp_idx_reg;
        settle_cnt_next = settle_cnt_reg;
        seq_err_next    = seq_err_reg;
        short_err_next  = short_err_reg;
        overflow_next   = overflow_reg || fifo_drop;
        frame_done_next = 1'b0;
        push            = 1'b0;

        // A convert falling edge always restarts the frame, abandoning any phase.
        if (conv_fall) begin
            state_next      = ARMED;
            exp_idx_next    = '0;
            settle_cnt_next = '0;
            seq_err_next    = 1'b0;
            short_err_next  = 1'b0;
            overflow_next   = 1'b0;
        end else if (state_reg != IDLE && multi_hot) begin
            seq_err_next = 1'b1;
            state_next   = ARMED;
        end else begin
            case (state_reg)
                ARMED: begin
                    if (rd_rise != 4'd0) begin
                        if (rd_rise == exp_onehot) begin
                            if (SETTLE_CYCLES == 1) begin
                                push       = 1'b1;
                                state_next = HOLD;
                            end else begin
                                settle_cnt_next = 3'd1;
                                state_next      = SETTLE;
                            end
                        end else begin
                            seq_err_next = 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    // Sample on the SETTLE_CYCLES-th posedge with the strobe high.
                    if (active) begin
                        if (settle_cnt_reg + 3'd1 >= SETTLE_C) begin
                            push       = 1'b1;
                            state_next = HOLD;
                        end else begin
                            settle_cnt_next = settle_cnt_reg + 3'd1;
                        end
                    end else begin
                        short_err_next  = 1'b1;
                        exp_idx_next    = exp_idx_reg + 2'd1;
                        frame_done_next = last_pix;
                        state_next      = last_pix ? IDLE : ARMED;
                    end
                end
                HOLD: begin
                    if (!active) begin
                        exp_idx_next    = exp_idx_reg + 2'd1;
                        frame_done_next = last_pix;
                        state_next      = last_pix ? IDLE : ARMED;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    pixel_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_pixel  = head_entry.pixel;
    assign out_idx    = head_entry.idx;
    assign frame_done = frame_done_reg;
    assign seq_err    = seq_err_reg;
    assign short_err  = short_err_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Scoreboard bench: strobes driven on negedge like the sequencer; a 4-deep
// and a 2-deep instance share the stimulus.
module tb_pixel_readout_capture;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       convert    = 1'b0;
    logic [3:0] rd         = 4'd0;
    logic [7:0] data_in    = 8'd0;
    logic       out_ready  = 1'b1;
    logic       out_ready2 = 1'b1;

    logic       out_valid, frame_done, seq_err, short_err, overflow;
    logic [7:0] out_pixel;
    logic [1:0] out_idx;
    logic       out_valid2, frame_done2, seq_err2, short_err2, overflow2;
    logic [7:0] out_pixel2;
    logic [1:0] out_idx2;

    int vectors     = 0;
    int miscompares = 0;
    int pops        = 0;
    int fd_count    = 0;
    int fd2_count   = 0;
    logic [9:0] exp_q [$];
    logic [9:0] mon_exp;

    always #5 clk = ~clk;

    pixel_readout_capture #(.DATA_W(8), .SETTLE_CYCLES(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .convert(convert),
        .read_1(rd[0]), .read_2(rd[1]), .read_3(rd[2]), .read_4(rd[3]),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_idx(out_idx), .frame_done(frame_done),
        .seq_err(seq_err), .short_err(short_err), .overflow(overflow)
    );

    pixel_readout_capture #(.DATA_W(8), .SETTLE_CYCLES(2), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .convert(convert),
        .read_1(rd[0]), .read_2(rd[1]), .read_3(rd[2]), .read_4(rd[3]),
        .data_in(data_in), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_pixel(out_pixel2), .out_idx(out_idx2), .frame_done(frame_done2),
        .seq_err(seq_err2), .short_err(short_err2), .overflow(overflow2)
    );

    // Prefix-XOR formulation of gray decoding.
    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b = 8'd0;
        for (int s = 0; s < 8; s++) b = b ^ (g >> s);
        return b;
    endfunction

    // Output monitor: every accepted head entry is checked against the scoreboard.
    always @(negedge clk) begin
        #1;
        if (reset && out_valid && out_ready) begin
            vectors++;
            pops++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out: got idx=%0d pixel=%0d, required no output", out_idx, out_pixel);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_idx, out_pixel} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL out_entry: got idx=%0d pixel=%0d, required idx=%0d pixel=%0d",
                             out_idx, out_pixel, mon_exp[9:8], mon_exp[7:0]);
                end else begin
                    $display("pop idx=%0d pixel=%0d", out_idx, out_pixel);
                end
            end
        end
        if (reset && frame_done)  fd_count++;
        if (reset && frame_done2) fd2_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_convert(input int len);
        @(negedge clk);
        convert = 1'b1;
        repeat (len) @(negedge clk);
        convert = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Strobe k (1..4) high for len cycles; returns at the negedge it drops.
    task automatic read_phase(input int k, input logic [7:0] g, input logic [7:0] exp_pix,
                              input int len, input bit expect_push);
        @(negedge clk);
        data_in   = g;
        rd[k-1]   = 1'b1;
        if (expect_push) exp_q.push_back({2'(k - 1), exp_pix});
        repeat (len) @(negedge clk);
        rd[k-1]   = 1'b0;
        data_in   = 8'd0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d entries outstanding, required 0", name, exp_q.size());
        end
        @(negedge clk);
        #2;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_empty: got out_valid=%b, required 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(3);
        #1;
        vectors++;
        if ({out_valid, out_pixel, out_idx, frame_done, seq_err, short_err, overflow} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, required all 0",
                     {out_valid, out_pixel, out_idx, frame_done, seq_err, short_err, overflow});
        end
        vectors++;
        if ({out_valid2, out_pixel2, out_idx2, frame_done2, seq_err2, short_err2, overflow2} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_outputs2: got %b, required all 0",
                     {out_valid2, out_pixel2, out_idx2, frame_done2, seq_err2, short_err2, overflow2});
        end
        @(negedge clk);
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_nominal();
        int fd0, fd20;
        out_ready  = 1'b1;
        out_ready2 = 1'b1;
        fd0  = fd_count;
        fd20 = fd2_count;
        do_convert(255);
        read_phase(1, 8'h00, 8'd0,   5, 1'b1);
        read_phase(2, 8'h07, 8'd5,   5, 1'b1);
        read_phase(3, 8'hAC, 8'd200, 5, 1'b1);
        read_phase(4, 8'h80, 8'd255, 5, 1'b1);
        @(negedge clk);
        #1;
        vectors++;
        if (frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL nominal_frame_done: got %b one cycle after read_4 fell, required 1", frame_done);
        end
        idle(4);
        #1;
        vectors++;
        if (fd_count - fd0 != 1 || fd2_count - fd20 != 1) begin
            miscompares++;
            $display("FAIL nominal_fd_pulses: got %0d/%0d, required 1/1", fd_count - fd0, fd2_count - fd20);
        end
        vectors++;
        if ({seq_err, short_err, overflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL nominal_flags: got seq/short/ovf=%b, required 000", {seq_err, short_err, overflow});
        end
        drain("nominal");
    endtask

    task automatic test_backpressure();
        int p0;
        out_ready  = 1'b0;
        out_ready2 = 1'b0;
        do_convert(4);
        read_phase(1, 8'h11, g2b(8'h11), 5, 1'b1);
        read_phase(2, 8'h22, g2b(8'h22), 5, 1'b1);
        #1;
        vectors++;
        if (overflow2 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ovf2_early: got %b after 2 captures, required 0", overflow2);
        end
        read_phase(3, 8'h33, g2b(8'h33), 5, 1'b1);
        #1;
        vectors++;
        if (overflow2 !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_ovf2_third: got %b after 3rd capture, required 1", overflow2);
        end
        read_phase(4, 8'h44, g2b(8'h44), 5, 1'b1);
        idle(2);
        #1;
        vectors++;
        if ({out_valid, overflow} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_depth4: got valid/ovf=%b, required 10", {out_valid, overflow});
        end
        vectors++;
        if ({out_valid2, overflow2} !== 2'b11) begin
            miscompares++;
            $display("FAIL bp_depth2: got valid/ovf=%b, required 11", {out_valid2, overflow2});
        end
        @(negedge clk);
        out_ready2 = 1'b1;
        #1;
        vectors++;
        if ({out_valid2, out_idx2, out_pixel2} !== {1'b1, 2'd0, g2b(8'h11)}) begin
            miscompares++;
            $display("FAIL bp_head2_0: got v=%b idx=%0d pix=%0d, required v=1 idx=0 pix=%0d",
                     out_valid2, out_idx2, out_pixel2, g2b(8'h11));
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({out_valid2, out_idx2, out_pixel2} !== {1'b1, 2'd1, g2b(8'h22)}) begin
            miscompares++;
            $display("FAIL bp_head2_1: got v=%b idx=%0d pix=%0d, required v=1 idx=1 pix=%0d",
                     out_valid2, out_idx2, out_pixel2, g2b(8'h22));
        end
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid2 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_depth2_kept: got out_valid2=%b after 2 pops, required 0", out_valid2);
        end
        p0 = pops;
        @(negedge clk);
        out_ready = 1'b1;
        drain("backpressure");
        vectors++;
        if (pops - p0 != 4) begin
            miscompares++;
            $display("FAIL bp_held: got %0d entries, required 4", pops - p0);
        end
    endtask

    task automatic test_out_of_order();
        out_ready = 1'b1;
        do_convert(4);
        read_phase(3, 8'h5A, 8'd0, 5, 1'b0);
        #1;
        vectors++;
        if ({seq_err, seq_err2} !== 2'b11) begin
            miscompares++;
            $display("FAIL ooo_seq_err: got %b, required 11", {seq_err, seq_err2});
        end
        read_phase(1, 8'h0F, g2b(8'h0F), 5, 1'b1);
        read_phase(2, 8'hC3, g2b(8'hC3), 5, 1'b1);
        read_phase(3, 8'h5A, g2b(8'h5A), 5, 1'b1);
        read_phase(4, 8'hFF, g2b(8'hFF), 5, 1'b1);
        idle(3);
        #1;
        vectors++;
        if ({seq_err, short_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL ooo_sticky: got seq/short=%b, required 10", {seq_err, short_err});
        end
        drain("out_of_order");
    endtask

    task automatic test_short();
        out_ready = 1'b1;
        do_convert(4);
        #1;
        vectors++;
        if (seq_err !== 1'b0) begin
            miscompares++;
            $display("FAIL short_rearm_clear: got seq_err=%b, required 0", seq_err);
        end
        read_phase(1, 8'hF0, 8'd0, 1, 1'b0);
        idle(1);
        #1;
        vectors++;
        if ({short_err, short_err2} !== 2'b11) begin
            miscompares++;
            $display("FAIL short_err: got %b, required 11", {short_err, short_err2});
        end
        read_phase(2, 8'h18, g2b(8'h18), 5, 1'b1);
        read_phase(3, 8'h81, g2b(8'h81), 5, 1'b1);
        read_phase(4, 8'h6E, g2b(8'h6E), 5, 1'b1);
        idle(3);
        #1;
        vectors++;
        if ({seq_err, short_err, overflow} !== 3'b010) begin
            miscompares++;
            $display("FAIL short_flags: got seq/short/ovf=%b, required 010", {seq_err, short_err, overflow});
        end
        drain("short");
    endtask

    task automatic test_full_pop();
        int p0;
        out_ready = 1'b0;
        do_convert(4);
        read_phase(1, 8'h21, g2b(8'h21), 5, 1'b1);
        read_phase(2, 8'h42, g2b(8'h42), 5, 1'b1);
        read_phase(3, 8'h63, g2b(8'h63), 5, 1'b1);
        read_phase(4, 8'h84, g2b(8'h84), 5, 1'b1);
        do_convert(4);
        p0 = pops;
        // Capture happens on the second posedge with read_1 high; pop on that edge only.
        @(negedge clk);
        data_in = 8'h99;
        rd[0]   = 1'b1;
        exp_q.push_back({2'd0, g2b(8'h99)});
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        vectors++;
        if ({out_valid, overflow} !== 2'b10 || pops - p0 != 1) begin
            miscompares++;
            $display("FAIL fullpop_edge: got valid/ovf=%b pops=%0d, required 10 pops=1",
                     {out_valid, overflow}, pops - p0);
        end
        idle(2);
        rd[0]   = 1'b0;
        data_in = 8'd0;
        idle(2);
        out_ready = 1'b1;
        drain("full_pop");
        vectors++;
        if (pops - p0 != 5 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL fullpop_count: got pops=%0d ovf=%b, required pops=5 ovf=0", pops - p0, overflow);
        end
    endtask

    task automatic test_reset_mid();
        int fd0;
        logic [7:0] g;
        out_ready = 1'b0;
        do_convert(4);
        read_phase(3, 8'h77, 8'd0, 3, 1'b0);
        read_phase(1, 8'h3C, g2b(8'h3C), 5, 1'b1);
        @(negedge clk);
        data_in = 8'h55;
        rd[1]   = 1'b1;
        @(negedge clk);
        #2;
        vectors++;
        if ({out_valid, seq_err} !== 2'b11) begin
            miscompares++;
            $display("FAIL rmid_pre: got valid/seq=%b, required 11", {out_valid, seq_err});
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_pixel, out_idx, frame_done, seq_err, short_err, overflow} !== 15'd0) begin
            miscompares++;
            $display("FAIL rmid_outputs: got %b, required all 0",
                     {out_valid, out_pixel, out_idx, frame_done, seq_err, short_err, overflow});
        end
        exp_q.delete();
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        idle(2);
        rd[1]   = 1'b0;
        data_in = 8'd0;
        fd0 = fd_count;
        read_phase(1, 8'h01, 8'd0, 5, 1'b0);
        read_phase(2, 8'h02, 8'd0, 5, 1'b0);
        read_phase(3, 8'h03, 8'd0, 5, 1'b0);
        read_phase(4, 8'h04, 8'd0, 5, 1'b0);
        idle(3);
        #1;
        vectors++;
        if ({out_valid, seq_err, short_err} !== 3'b000 || fd_count != fd0) begin
            miscompares++;
            $display("FAIL rmid_ignored: got valid/seq/short=%b fd=%0d, required 000 fd=0",
                     {out_valid, seq_err, short_err}, fd_count - fd0);
        end
        do_convert(4);
        for (int k = 1; k <= 4; k++) begin
            g = 8'($urandom_range(0, 255));
            read_phase(k, g, g2b(g), 4, 1'b1);
        end
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_out_of_order();
        test_short();
        test_full_pop();
        test_reset_mid();
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
